seq_div: RTL and testbench
==========================

Name: seq_div

Overview:
- Sequential unsigned restoring divider, the inverse of the team's 16x16 shift-add multiplier.
- Divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor and produces a WIDTH-bit quotient and a WIDTH-bit remainder, one quotient bit per cycle.
- Each trial subtraction is done by the existing FA32 adder using two's-complement add (inverted operand, cin=1).
- Uses the same start/ready/result-hold handshake as the multiplier, so datapath code can drive either unit the same way.

Parameters:
- WIDTH, 16, divisor/quotient/remainder width. Legal range 4..16, so that WIDTH+1 bits fit inside FA32.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  synchronous start, sampled on posedge.
- dividend  input  2*WIDTH  unsigned dividend; sampled only when start=1.
- divisor  input  WIDTH  unsigned divisor; sampled only when start=1.
- ready  output  1  high when a result (or error) is valid.
- quotient  output  WIDTH  quotient; 0 whenever ready=0.
- remainder  output  WIDTH  remainder; 0 whenever ready=0.
- div_by_zero  output  1  error flag: divisor was 0; valid only while ready=1.
- overflow  output  1  error flag: quotient would not fit in WIDTH bits; valid only while ready=1.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (ports clk, reset).
- Reset, evaluated at posedge, dominates start:
  - state=IDLE, counter=0, all internal registers 0.
  - ready=0, quotient=0, remainder=0, div_by_zero=0, overflow=0.
- States: IDLE, BUSY, DONE.
- start=1 at any posedge without reset, in any state (including mid-BUSY), aborts any operation in progress and latches:
  - rem_reg (WIDTH+1 bits) = {0, dividend[2W-1:W]}
  - q_reg = dividend[W-1:0]
  - dsr_reg = divisor
  - counter = 0
  - It also evaluates errors from the input values:
    - divisor==0 -> state=DONE, div_by_zero=1, overflow=0, quotient=0, remainder=0.
    - otherwise, dividend[2W-1:W] >= divisor -> state=DONE, overflow=1, quotient=0, remainder=0.
    - otherwise -> state=BUSY, ready=0.
  - On the error paths ready=1 is visible the cycle after the start edge.
- BUSY iteration, each posedge with start=0:
  - t = {rem_reg[W-1:0], q_reg[W-1]} (W+1 bits).
  - FA32 a={zero-extended t}, b=~{zero-extended dsr_reg}, cin=1; diff = sum[W:0], no_borrow = cout.
  - If no_borrow: rem_reg=diff, q_reg={q_reg[W-2:0],1}. Else: rem_reg=t, q_reg={q_reg[W-2:0],0}.
  - counter++.
  - On the posedge where counter==W-1 the last bit is produced; state becomes DONE.
- Latency: start edge E0; iterations at E1..EW; ready=1, quotient=q_reg, remainder=rem_reg[W-1:0] visible after EW (16 cycles for WIDTH=16).
- DONE: ready, quotient, remainder and flags hold indefinitely until the next start or reset. start=1 in DONE restarts normally.
- IDLE: ready=0, outputs 0; remains in IDLE until start.
- Invariants:
  - dividend/divisor changes while start=0 have no effect.
  - ready never glitches high during BUSY.
  - flags are never both 1.
- Arithmetic check: on success, dividend == quotient*divisor + remainder and remainder < divisor.

Decomposition:
- Package div_pkg:
  - typedef enum logic [1:0] div_state_t {IDLE, BUSY, DONE}.
  - localparam CNT_W = $clog2(16)+1.
  - localparam FA_W = 32.
- Sub-module: the existing FA32, instantiated once as the trial subtractor. No new sub-module; the FSM and shift registers live in seq_div.

Test Plan:
- Basic: reset 2 cycles; start with dividend=100000, divisor=300 -> ready=0 for cycles 1..15, ready=1 after 16th edge with quotient=333, remainder=100, flags 0; held for 10 further idle cycles.
- Max values: dividend=0xFFFE0001, divisor=0xFFFF -> quotient=0xFFFF, remainder=0 after 16 cycles. Also dividend=0x0000FFFF, divisor=1 -> quotient=0xFFFF, remainder=0.
- Errors:
  - dividend=1234, divisor=0 -> ready=1 one cycle after start, div_by_zero=1, overflow=0, quotient=0, remainder=0.
  - dividend=0x00050000, divisor=5 -> ready=1 next cycle, overflow=1.
- Restart: start 1000/7, then start 50/6 at cycle 5 of BUSY -> ready stays 0 until 16 cycles after the second start, then quotient=8, remainder=2.
- Reset mid-op: start 100000/300, assert reset together with start=1 at cycle 8 -> next cycle all outputs 0, state IDLE, no ready pulse ever appears.
- Random: 1000 random legal operand pairs, back-to-back start on the cycle after each ready -> quotient and remainder match the reference model, latency exactly 16 each time.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the sequential divider.
package div_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;
  localparam int CNT_W = $clog2(16) + 1;
  localparam int FA_W = 32;
endpackage

// File: rtl/seq_div_fa32.sv
// fa32: 32-bit adder with carry in/out, used as the divider's trial subtractor.
module fa32
  import div_pkg::*;
(
  input  logic [FA_W-1:0] a,
  input  logic [FA_W-1:0] b,
  input  logic            cin,
  output logic [FA_W-1:0] sum,
  output logic            cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{FA_W{1'b0}}, cin};
endmodule

// File: rtl/seq_div.sv
// seq_div: sequential restoring divider, 2W/W -> W quotient and W remainder, one bit per cycle.
module seq_div
  import div_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               overflow
);
  localparam int W = WIDTH;
  div_state_t state;
  logic [W:0] rem_reg, t, diff;
  logic [W-1:0] q_reg, dsr_reg, hi;
  logic [CNT_W-1:0] cnt;
  logic [FA_W-1:0] sum;
  logic dbz, ovf, no_borrow, ok, unused_bits;
  assign hi = dividend[2*W-1:W];
  assign t = {rem_reg[W-1:0], q_reg[W-1]};
  // Subtract via a + ~b + 1; carry out means the trial subtraction did not borrow.
  fa32 u_sub (
    .a   (FA_W'(t)),
    .b   (~FA_W'(dsr_reg)),
    .cin (1'b1),
    .sum (sum),
    .cout(no_borrow)
  );
  assign diff = sum[W:0];
  assign unused_bits = ^{sum[FA_W-1:W+1], rem_reg[W]};
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rem_reg <= '0;
      q_reg   <= '0;
      dsr_reg <= '0;
      cnt     <= '0;
      dbz     <= 1'b0;
      ovf     <= 1'b0;
    end else if (start) begin
      rem_reg <= {1'b0, hi};
      q_reg   <= dividend[W-1:0];
      dsr_reg <= divisor;
      cnt     <= '0;
      dbz     <= divisor == '0;
      ovf     <= divisor != '0 && hi >= divisor;
      state   <= (divisor == '0 || hi >= divisor) ? DONE : BUSY;
    end else if (state == BUSY) begin
      rem_reg <= no_borrow ? diff : t;
      q_reg   <= {q_reg[W-2:0], no_borrow};
      cnt     <= cnt + CNT_W'(1);
      if (cnt == CNT_W'(W - 1)) state <= DONE;
    end
  end
  assign ready = state == DONE;
  assign ok = ready && !dbz && !ovf;
  assign quotient = ok ? q_reg : '0;
  assign remainder = ok ? rem_reg[W-1:0] : '0;
  assign div_by_zero = ready && dbz;
  assign overflow = ready && ovf;
endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: scoreboard bench for seq_div against an arithmetic reference model.
module tb_seq_div;
  localparam int W = 16;
  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    logic        ovf;
    int          cyc;
  } exp_t;
  logic clk = 0, reset = 1, start = 0;
  logic [31:0] dividend = 0;
  logic [15:0] divisor = 0;
  logic ready, div_by_zero, overflow;
  logic [15:0] quotient, remainder;
  exp_t sb[$];
  exp_t held;
  bit held_valid = 0, armed = 0;
  int cyc = 0, checks = 0, errors = 0;

  seq_div #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .ready(ready), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] n, input logic [15:0] d, input int c);
    exp_t e;
    e.cyc = c; e.q = 0; e.r = 0; e.dbz = 0; e.ovf = 0;
    if (d == 0) e.dbz = 1;
    else if (n / {16'h0, d} > 32'hFFFF) e.ovf = 1;
    else begin
      e.q = 16'(n / {16'h0, d});
      e.r = 16'(n % {16'h0, d});
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (armed) begin
      if (ready) begin
        if (sb.size() > 0) begin
          held = sb.pop_front();
          held_valid = 1;
          check("latency", 64'(cyc - held.cyc), (held.dbz || held.ovf) ? 64'd0 : 64'(W));
        end
        if (!held_valid) check("spurious_ready", ready, 0);
        else begin
          check("quotient", quotient, held.q);
          check("remainder", remainder, held.r);
          check("div_by_zero", div_by_zero, held.dbz);
          check("overflow", overflow, held.ovf);
        end
      end else
        check("idle_outputs_zero", {quotient, remainder, div_by_zero, overflow}, 0);
    end
  end

  task automatic do_reset(input logic with_start);
    reset = 1; start = with_start;
    @(posedge clk); #1;
    reset = 0; start = 0;
    sb.delete(); held_valid = 0; armed = 1;
  endtask

  task automatic do_start(input logic [31:0] n, input logic [15:0] d);
    start = 1; dividend = n; divisor = d;
    @(posedge clk); #1;
    start = 0; dividend = $urandom; divisor = 16'($urandom);
    if (sb.size() > 0) void'(sb.pop_back());
    sb.push_back(model(n, d, cyc));
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0) return;
    end
    checks++; errors++;
    $display("FAIL timeout waiting for ready after %0d cycles", budget);
    sb.delete();
  endtask

  initial begin
    do_reset(0);
    do_reset(0);
    do_start(32'd100000, 16'd300);
    wait_done(40);
    repeat (10) @(posedge clk);
    #1;
    do_start(32'hFFFE0001, 16'hFFFF);
    wait_done(40);
    do_start(32'h0000FFFF, 16'd1);
    wait_done(40);
    do_start(32'd1234, 16'd0);
    wait_done(5);
    repeat (3) @(posedge clk);
    #1;
    do_start(32'h00050000, 16'd5);
    wait_done(5);
    repeat (3) @(posedge clk);
    #1;
    do_start(32'd1000, 16'd7);
    repeat (4) @(posedge clk);
    #1;
    do_start(32'd50, 16'd6);
    wait_done(40);
    do_start(32'd100000, 16'd300);
    repeat (7) @(posedge clk);
    #1;
    do_reset(1);
    repeat (30) @(posedge clk);
    #1;
    for (int k = 0; k < 1000; k++) begin
      logic [15:0] d, h;
      d = 16'($urandom_range(1, 65535));
      h = 16'($urandom_range(0, int'(d) - 1));
      do_start({h, 16'($urandom)}, d);
      wait_done(40);
    end
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
